// File: rtl/ex_issue_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_issue_stage_pkg
//   Shared constants and types for the WISC execute-stage front end:
//   opcode and func encodings, 4-bit ALU op codes, operand-select enums, the
//   decoded-control struct, and small helpers for op mapping and branch
//   conditions.
// ----------------------------------------------------------------------------
package ex_issue_stage_pkg;

   // WISC opcodes (instruction bits [15:11])
   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_NOP   = 5'b00001;
   localparam logic [4:0] OP_SIIC  = 5'b00010;
   localparam logic [4:0] OP_RTI   = 5'b00011;
   localparam logic [4:0] OP_J     = 5'b00100;
   localparam logic [4:0] OP_JR    = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;
   localparam logic [4:0] OP_JALR  = 5'b00111;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_SUBI  = 5'b01001;
   localparam logic [4:0] OP_XORI  = 5'b01010;
   localparam logic [4:0] OP_ANDNI = 5'b01011;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_BLTZ  = 5'b01110;
   localparam logic [4:0] OP_BGEZ  = 5'b01111;
   localparam logic [4:0] OP_ST    = 5'b10000;
   localparam logic [4:0] OP_LD    = 5'b10001;
   localparam logic [4:0] OP_SLBI  = 5'b10010;
   localparam logic [4:0] OP_STU   = 5'b10011;
   localparam logic [4:0] OP_ROLI  = 5'b10100;
   localparam logic [4:0] OP_SLLI  = 5'b10101;
   localparam logic [4:0] OP_RORI  = 5'b10110;
   localparam logic [4:0] OP_SRLI  = 5'b10111;
   localparam logic [4:0] OP_LBI   = 5'b11000;
   localparam logic [4:0] OP_BTR   = 5'b11001;
   localparam logic [4:0] OP_SHF_R = 5'b11010;
   localparam logic [4:0] OP_ALU_R = 5'b11011;
   localparam logic [4:0] OP_SEQ   = 5'b11100;
   localparam logic [4:0] OP_SLT   = 5'b11101;
   localparam logic [4:0] OP_SLE   = 5'b11110;
   localparam logic [4:0] OP_SCO   = 5'b11111;

   // R-type arithmetic func codes
   localparam logic [1:0] FN_ADD  = 2'b00;
   localparam logic [1:0] FN_SUB  = 2'b01;
   localparam logic [1:0] FN_XOR  = 2'b10;
   localparam logic [1:0] FN_ANDN = 2'b11;

   // ALU op codes
   localparam logic [3:0] ALU_SUB  = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_ANDN = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_ROL  = 4'b0100;
   localparam logic [3:0] ALU_BTR  = 4'b1000;
   localparam logic [3:0] ALU_SEQ  = 4'b1001;
   localparam logic [3:0] ALU_PASS = 4'b1101;
   localparam logic [3:0] ALU_SLBI = 4'b1110;

   typedef enum logic [1:0] {A_RS, A_RT, A_IMM, A_ZERO} a_sel_t;
   typedef enum logic [1:0] {B_RS, B_RT, B_IMM, B_IMM8} b_sel_t;

   typedef struct packed {
      logic [3:0] alu_op;
      a_sel_t     a_sel;
      b_sel_t     b_sel;
      logic       is_branch;
      logic       is_jump;
      logic       jump_reg;   // target base is rs instead of pc_inc
      logic       link;       // JAL/JALR: write pc_inc to R7
      logic       wr_en;
   } dec_t;

   // Arithmetic group shares one encoding for R-type func and immediate opcode[1:0]
   function automatic logic [3:0] arith_op(input logic [1:0] sel);
      case (sel)
         FN_ADD:  arith_op = ALU_ADD;
         FN_SUB:  arith_op = ALU_SUB;
         FN_XOR:  arith_op = ALU_XOR;
         default: arith_op = ALU_ANDN;
      endcase
   endfunction

   // Shift group: ROL/SLL/ROR/SRL map to consecutive ops starting at 0100
   function automatic logic [3:0] shift_op(input logic [1:0] sel);
      shift_op = ALU_ROL + {2'b00, sel};
   endfunction

   // Branch condition selected by opcode[1:0]: BEQZ/BNEZ/BLTZ/BGEZ
   function automatic logic branch_cond(input logic [1:0] sel, input logic msb,
                                        input logic zero);
      case (sel)
         2'b00:   branch_cond = zero;
         2'b01:   branch_cond = ~zero;
         2'b10:   branch_cond = msb;
         default: branch_cond = ~msb;
      endcase
   endfunction

endpackage

// File: rtl/ex_issue_stage_alu_op_decode.sv
// ----------------------------------------------------------------------------
// ex_issue_stage_alu_op_decode
//   Purely combinational decode of a WISC opcode/func pair into ALU op,
//   operand selects and control-transfer / writeback flags.
//   Ports:
//     opcode  in  5   instruction opcode
//     func    in  2   R-type func field
//     dec     out     decoded control (dec_t)
//   Unknown opcodes (HALT/NOP/SIIC/RTI) fall through as a pass-through op
//   with no register write.
// ----------------------------------------------------------------------------
module ex_issue_stage_alu_op_decode
   import ex_issue_stage_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic [1:0] func,
   output dec_t       dec
);

   always_comb begin
      dec           = '0;
      dec.alu_op    = ALU_PASS;
      dec.a_sel     = A_RS;
      dec.b_sel     = B_IMM;
      case (opcode)
         OP_ALU_R: begin
            dec.alu_op = arith_op(func);
            // SUB computes rt - rs, so the operands swap
            dec.a_sel  = (func == FN_SUB) ? A_RT : A_RS;
            dec.b_sel  = (func == FN_SUB) ? B_RS : B_RT;
            dec.wr_en  = 1'b1;
         end
         OP_SHF_R: begin
            dec.alu_op = shift_op(func);
            dec.b_sel  = B_RT;
            dec.wr_en  = 1'b1;
         end
         OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
            dec.alu_op = arith_op(opcode[1:0]);
            // SUBI computes imm - rs
            dec.a_sel  = (opcode == OP_SUBI) ? A_IMM : A_RS;
            dec.b_sel  = (opcode == OP_SUBI) ? B_RS : B_IMM;
            dec.wr_en  = 1'b1;
         end
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
            dec.alu_op = shift_op(opcode[1:0]);
            dec.wr_en  = 1'b1;
         end
         OP_BTR: begin
            dec.alu_op = ALU_BTR;
            dec.b_sel  = B_RT;
            dec.wr_en  = 1'b1;
         end
         OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
            dec.alu_op = ALU_SEQ + {2'b00, opcode[1:0]};
            dec.b_sel  = B_RT;
            dec.wr_en  = 1'b1;
         end
         OP_LBI: begin
            dec.a_sel  = A_ZERO;
            dec.wr_en  = 1'b1;
         end
         OP_SLBI: begin
            dec.alu_op = ALU_SLBI;
            dec.b_sel  = B_IMM8;
            dec.wr_en  = 1'b1;
         end
         OP_LD, OP_STU: begin
            dec.alu_op = ALU_ADD;
            dec.wr_en  = 1'b1;
         end
         OP_ST: begin
            dec.alu_op = ALU_ADD;
         end
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
            dec.is_branch = 1'b1;
         end
         OP_J: begin
            dec.is_jump = 1'b1;
         end
         OP_JR: begin
            dec.is_jump  = 1'b1;
            dec.jump_reg = 1'b1;
         end
         OP_JAL: begin
            dec.is_jump = 1'b1;
            dec.link    = 1'b1;
            dec.wr_en   = 1'b1;
         end
         OP_JALR: begin
            dec.is_jump  = 1'b1;
            dec.jump_reg = 1'b1;
            dec.link     = 1'b1;
            dec.wr_en    = 1'b1;
         end
         default: begin
            // HALT, NOP, SIIC, RTI: pass-through, no write
         end
      endcase
   end

endmodule

// File: rtl/ex_issue_stage.sv
// ----------------------------------------------------------------------------
// ex_issue_stage
//   Execute-stage front end for the 16-bit WISC core. S1 holds the issued
//   instruction and drives the external ALU combinationally; S2 registers the
//   result toward MEM/WB. Branches and jumps resolve in S1 and raise a
//   one-cycle redirect to fetch when S1 advances.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready         decoded-instruction handshake
//     in_opcode, in_func        opcode [15:11], R-type func
//     in_rs, in_rt, in_imm      operands, pre-extended immediate
//     in_pc_inc, in_wr_reg      PC+2, destination register
//     alu_in_a/b, alu_op        ALU request (combinational from S1)
//     alu_out, alu_msb/zero     ALU result and flags of alu_in_a
//     out_valid/out_ready       S2 handshake
//     out_result/wr_reg/wr_en   registered writeback info
//     redirect, redirect_pc     one-cycle fetch redirect
//     flush                     kills S1 and S2 and any pending redirect
// ----------------------------------------------------------------------------
module ex_issue_stage
   import ex_issue_stage_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_opcode,
   input  logic [1:0]    in_func,
   input  logic [DW-1:0] in_rs,
   input  logic [DW-1:0] in_rt,
   input  logic [DW-1:0] in_imm,
   input  logic [DW-1:0] in_pc_inc,
   input  logic [RW-1:0] in_wr_reg,
   output logic [DW-1:0] alu_in_a,
   output logic [DW-1:0] alu_in_b,
   output logic [3:0]    alu_op,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_msb,
   input  logic          alu_zero,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic [RW-1:0] out_wr_reg,
   output logic          out_wr_en,
   output logic          redirect,
   output logic [DW-1:0] redirect_pc,
   input  logic          flush
);

   // S1 state
   logic          s1_valid_reg;
   logic [4:0]    s1_opcode_reg;
   logic [1:0]    s1_func_reg;
   logic [DW-1:0] s1_rs_reg;
   logic [DW-1:0] s1_rt_reg;
   logic [DW-1:0] s1_imm_reg;
   logic [DW-1:0] s1_pc_inc_reg;
   logic [RW-1:0] s1_dst_reg;

   // S2 state
   logic          out_valid_reg;
   logic [DW-1:0] out_result_reg;
   logic [RW-1:0] out_wr_reg_reg;
   logic          out_wr_en_reg;

   // Redirect state
   logic          redirect_reg;
   logic [DW-1:0] redirect_pc_reg;

   // Handshake and control
   logic          s2_adv;
   logic          s1_adv;
   logic          accept;
   logic          taken;
   logic          redirect_fire;
   logic [DW-1:0] target;
   dec_t          dec;

   ex_issue_stage_alu_op_decode u_dec (
      .opcode (s1_opcode_reg),
      .func   (s1_func_reg),
      .dec    (dec)
   );

   assign s2_adv   = ~out_valid_reg | out_ready;
   assign s1_adv   = s1_valid_reg & s2_adv;
   assign in_ready = ~s1_valid_reg | s1_adv;
   assign accept   = in_valid & in_ready;

   // Flags come from the ALU, which sees alu_in_a = rs for every control transfer
   assign taken = s1_valid_reg &
                  (dec.is_jump | (dec.is_branch & branch_cond(s1_opcode_reg[1:0], alu_msb, alu_zero)));

   // Dedicated target adder so the ALU stays free for the link/pass result
   assign target = (dec.jump_reg ? s1_rs_reg : s1_pc_inc_reg) + s1_imm_reg;

   // A redirect fires only when the instruction leaves S1, so stalls cannot repeat it
   assign redirect_fire = s1_adv & taken & ~flush;

   // Operand routing
   always_comb begin
      alu_in_a = s1_rs_reg;
      case (dec.a_sel)
         A_RS:    alu_in_a = s1_rs_reg;
         A_RT:    alu_in_a = s1_rt_reg;
         A_IMM:   alu_in_a = s1_imm_reg;
         default: alu_in_a = '0;
      endcase
   end

   always_comb begin
      alu_in_b = s1_imm_reg;
      case (dec.b_sel)
         B_RS:    alu_in_b = s1_rs_reg;
         B_RT:    alu_in_b = s1_rt_reg;
         B_IMM:   alu_in_b = s1_imm_reg;
         default: alu_in_b = {{(DW-8){1'b0}}, s1_imm_reg[7:0]};
      endcase
   end

   assign alu_op = dec.alu_op;

   // S1 register. An instruction arriving alongside a taken transfer is on the
   // wrong path and is discarded.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         s1_valid_reg <= 1'b0;
      end else if (accept && !(s1_adv && taken)) begin
         s1_valid_reg <= 1'b1;
      end else if (s1_adv) begin
         s1_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_opcode_reg <= OP_NOP;
         s1_func_reg   <= '0;
         s1_rs_reg     <= '0;
         s1_rt_reg     <= '0;
         s1_imm_reg    <= '0;
         s1_pc_inc_reg <= '0;
         s1_dst_reg    <= '0;
      end else if (accept) begin
         s1_opcode_reg <= in_opcode;
         s1_func_reg   <= in_func;
         s1_rs_reg     <= in_rs;
         s1_rt_reg     <= in_rt;
         s1_imm_reg    <= in_imm;
         s1_pc_inc_reg <= in_pc_inc;
         s1_dst_reg    <= in_wr_reg;
      end
   end

   // S2 register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         out_result_reg <= '0;
         out_wr_reg_reg <= '0;
         out_wr_en_reg  <= 1'b0;
      end else if (flush) begin
         out_valid_reg  <= 1'b0;
      end else if (s2_adv) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_result_reg <= dec.link ? s1_pc_inc_reg : alu_out;
            out_wr_reg_reg <= dec.link ? {RW{1'b1}} : s1_dst_reg;
            out_wr_en_reg  <= dec.wr_en;
         end
      end
   end

   // Redirect register: single-cycle pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_reg    <= 1'b0;
         redirect_pc_reg <= '0;
      end else begin
         redirect_reg <= redirect_fire;
         if (redirect_fire) begin
            redirect_pc_reg <= target;
         end
      end
   end

   assign out_valid   = out_valid_reg;
   assign out_result  = out_result_reg;
   assign out_wr_reg  = out_wr_reg_reg;
   assign out_wr_en   = out_wr_en_reg;
   assign redirect    = redirect_reg;
   assign redirect_pc = redirect_pc_reg;

endmodule

// File: tb/tb_ex_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_issue_stage
//   Directed bench for ex_issue_stage with a behavioural ALU attached.
// ----------------------------------------------------------------------------
module tb_ex_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_opcode;
   logic [1:0]  in_func;
   logic [15:0] in_rs, in_rt, in_imm, in_pc_inc;
   logic [2:0]  in_wr_reg;
   logic [15:0] alu_in_a, alu_in_b, alu_out;
   logic [3:0]  alu_op;
   logic        alu_msb, alu_zero;
   logic        out_valid, out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_wr_reg;
   logic        out_wr_en;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        flush;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   ex_issue_stage #(.DW(16), .RW(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_func(in_func),
      .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
      .in_pc_inc(in_pc_inc), .in_wr_reg(in_wr_reg),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_msb(alu_msb), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_wr_reg(out_wr_reg), .out_wr_en(out_wr_en),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush)
   );

   // Behavioural ALU (subset sufficient for the directed vectors)
   always_comb begin
      alu_out = alu_in_b;
      case (alu_op)
         4'b0000: alu_out = alu_in_a - alu_in_b;
         4'b0001: alu_out = alu_in_a + alu_in_b;
         4'b0010: alu_out = alu_in_a & ~alu_in_b;
         4'b0011: alu_out = alu_in_a ^ alu_in_b;
         4'b0101: alu_out = alu_in_a << alu_in_b[3:0];
         4'b0111: alu_out = alu_in_a >> alu_in_b[3:0];
         4'b1110: alu_out = {alu_in_a[7:0], alu_in_b[7:0]};
         default: alu_out = alu_in_b;
      endcase
   end
   assign alu_msb  = alu_in_a[15];
   assign alu_zero = (alu_in_a == 16'h0000);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic offer(input logic [4:0] op, input logic [1:0] fn, input logic [15:0] rs,
                        input logic [15:0] rt, input logic [15:0] imm,
                        input logic [15:0] pc, input logic [2:0] wr);
      in_valid  = 1'b1;
      in_opcode = op;
      in_func   = fn;
      in_rs     = rs;
      in_rt     = rt;
      in_imm    = imm;
      in_pc_inc = pc;
      in_wr_reg = wr;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_opcode = 5'b00001; in_func = 2'b00;
      in_rs = '0; in_rt = '0; in_imm = '0; in_pc_inc = '0; in_wr_reg = '0;

      // ---- Reset state ----
      tick(); tick();
      rst = 1'b0;
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_out_result", out_result, 16'h0000);
      check("rst_out_wr_reg", {13'd0, out_wr_reg}, 16'd0);
      check("rst_out_wr_en", {15'd0, out_wr_en}, 16'd0);
      check("rst_redirect", {15'd0, redirect}, 16'd0);
      check("rst_redirect_pc", redirect_pc, 16'h0000);
      check("rst_in_ready", {15'd0, in_ready}, 16'd1);
      $display("reset: out_valid=%0d redirect=%0d in_ready=%0d", out_valid, redirect, in_ready);

      // ---- ADD, SUB, SUBI back to back ----
      offer(5'b11011, 2'b00, 16'd3, 16'd4, 16'd0, 16'd0, 3'd2);
      tick();
      check("add_alu_op", {12'd0, alu_op}, 16'h0001);
      check("add_alu_a", alu_in_a, 16'd3);
      check("add_alu_b", alu_in_b, 16'd4);
      offer(5'b11011, 2'b01, 16'd2, 16'd9, 16'd0, 16'd0, 3'd3);
      tick();
      check("add_out_valid", {15'd0, out_valid}, 16'd1);
      check("add_out_result", out_result, 16'd7);
      check("add_out_wr_en", {15'd0, out_wr_en}, 16'd1);
      check("add_out_wr_reg", {13'd0, out_wr_reg}, 16'd2);
      check("sub_alu_a", alu_in_a, 16'd9);
      check("sub_alu_b", alu_in_b, 16'd2);
      check("sub_alu_op", {12'd0, alu_op}, 16'h0000);
      $display("ADD: result=%0d wr_reg=%0d wr_en=%0d", out_result, out_wr_reg, out_wr_en);
      offer(5'b01001, 2'b00, 16'd1, 16'd0, 16'd5, 16'd0, 3'd4);
      tick();
      in_valid = 1'b0;
      check("sub_out_result", out_result, 16'd7);
      check("sub_out_wr_reg", {13'd0, out_wr_reg}, 16'd3);
      check("subi_alu_a", alu_in_a, 16'd5);
      check("subi_alu_b", alu_in_b, 16'd1);
      $display("SUB: result=%0d wr_reg=%0d", out_result, out_wr_reg);
      tick();
      check("subi_out_result", out_result, 16'd4);
      check("subi_out_wr_reg", {13'd0, out_wr_reg}, 16'd4);
      $display("SUBI: result=%0d wr_reg=%0d", out_result, out_wr_reg);
      tick();
      check("drain_out_valid", {15'd0, out_valid}, 16'd0);

      // ---- BEQZ taken, same-cycle accept dropped ----
      offer(5'b01100, 2'b00, 16'd0, 16'd0, 16'h0006, 16'h0010, 3'd1);
      tick();
      offer(5'b01000, 2'b00, 16'd1, 16'd0, 16'd1, 16'h0012, 3'd5);
      check("beqz_in_ready", {15'd0, in_ready}, 16'd1);
      tick();
      in_valid = 1'b0;
      check("beqz_redirect", {15'd0, redirect}, 16'd1);
      check("beqz_redirect_pc", redirect_pc, 16'h0016);
      check("beqz_out_valid", {15'd0, out_valid}, 16'd1);
      check("beqz_out_wr_en", {15'd0, out_wr_en}, 16'd0);
      $display("BEQZ taken: redirect=%0d pc=%04h", redirect, redirect_pc);
      tick();
      check("beqz_pulse_end", {15'd0, redirect}, 16'd0);
      check("beqz_drop", {15'd0, out_valid}, 16'd0);

      // ---- BEQZ not taken ----
      offer(5'b01100, 2'b00, 16'd1, 16'd0, 16'h0006, 16'h0010, 3'd1);
      tick();
      in_valid = 1'b0;
      tick();
      check("beqz_nt_redirect", {15'd0, redirect}, 16'd0);
      check("beqz_nt_out_valid", {15'd0, out_valid}, 16'd1);
      $display("BEQZ not taken: redirect=%0d out_valid=%0d", redirect, out_valid);
      tick();

      // ---- JAL ----
      offer(5'b00110, 2'b00, 16'h1234, 16'd0, 16'hFFFE, 16'h0100, 3'd2);
      tick();
      in_valid = 1'b0;
      tick();
      check("jal_redirect", {15'd0, redirect}, 16'd1);
      check("jal_redirect_pc", redirect_pc, 16'h00FE);
      check("jal_out_result", out_result, 16'h0100);
      check("jal_out_wr_reg", {13'd0, out_wr_reg}, 16'd7);
      check("jal_out_wr_en", {15'd0, out_wr_en}, 16'd1);
      $display("JAL: redirect_pc=%04h result=%04h wr_reg=%0d", redirect_pc, out_result, out_wr_reg);
      tick();
      check("jal_pulse_end", {15'd0, redirect}, 16'd0);

      // ---- Stall: out_ready low for 3 cycles ----
      out_ready = 1'b0;
      offer(5'b01000, 2'b00, 16'd10, 16'd0, 16'd1, 16'd0, 3'd1);
      tick();
      offer(5'b01000, 2'b00, 16'd20, 16'd0, 16'd1, 16'd0, 3'd2);
      tick();
      offer(5'b01000, 2'b00, 16'd30, 16'd0, 16'd1, 16'd0, 3'd3);
      check("stall_in_ready", {15'd0, in_ready}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_out_valid", {15'd0, out_valid}, 16'd1);
         check("stall_out_result", out_result, 16'd11);
         check("stall_alu_a", alu_in_a, 16'd20);
         check("stall_in_ready_hold", {15'd0, in_ready}, 16'd0);
         $display("stall cycle %0d: result=%0d alu_a=%0d in_ready=%0d", i, out_result, alu_in_a, in_ready);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("release_b_result", out_result, 16'd21);
      check("release_b_wr_reg", {13'd0, out_wr_reg}, 16'd2);
      tick();
      check("release_c_result", out_result, 16'd31);
      check("release_c_wr_reg", {13'd0, out_wr_reg}, 16'd3);
      tick();
      check("release_empty", {15'd0, out_valid}, 16'd0);
      $display("stall release: drained, out_valid=%0d", out_valid);

      // ---- flush with S1 = taken BLTZ, S2 full ----
      offer(5'b01000, 2'b00, 16'd1, 16'd0, 16'd1, 16'd0, 3'd1);
      tick();
      offer(5'b01110, 2'b00, 16'h8000, 16'd0, 16'h0020, 16'h0040, 3'd0);
      tick();
      offer(5'b01000, 2'b00, 16'd2, 16'd0, 16'd1, 16'd0, 3'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_redirect", {15'd0, redirect}, 16'd0);
      check("flush_out_valid", {15'd0, out_valid}, 16'd0);
      tick();
      check("flush_drop_redirect", {15'd0, redirect}, 16'd0);
      check("flush_drop_out_valid", {15'd0, out_valid}, 16'd0);
      $display("flush: redirect=%0d out_valid=%0d", redirect, out_valid);

      // ---- rst with S1 = taken BLTZ, S2 full ----
      offer(5'b01000, 2'b00, 16'd1, 16'd0, 16'd1, 16'd0, 3'd1);
      tick();
      offer(5'b01110, 2'b00, 16'h8000, 16'd0, 16'h0020, 16'h0040, 3'd0);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_redirect", {15'd0, redirect}, 16'd0);
      check("rst2_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst2_out_result", out_result, 16'h0000);
      check("rst2_out_wr_en", {15'd0, out_wr_en}, 16'd0);
      tick();
      check("rst2_after_redirect", {15'd0, redirect}, 16'd0);
      check("rst2_after_out_valid", {15'd0, out_valid}, 16'd0);
      $display("rst mid-op: redirect=%0d out_valid=%0d", redirect, out_valid);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
